adjacent_difference_1x8x32bit: RTL and testbench

Custom SIMD instruction unit that inverts PrefixSum1x8x32bit. It is the decoder for the prefix-sum encoder: each output lane is the input lane minus the preceding input element, so decode(prefix_sum(x)) == x across consecutive vectors. The preceding element of lane 0 is the last element of the previous vector in the same stream. It sits beside the sorter, merger and prefix-sum units in the custom-instruction execute stage and uses the same in_v/vrd -> out_v/out_vrd convention, with no backpressure.

---
 rtl/adjacent_difference_1x8x32bit_pkg.sv | 19 +
 rtl/adjacent_difference_1x8x32bit_sub.sv | 45 ++++
 rtl/adjacent_difference_1x8x32bit.sv | 84 ++++++++
 tb/tb_adjacent_difference_1x8x32bit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adjacent_difference_1x8x32bit_pkg.sv
// Shared constants and helpers for the adjacent-difference SIMD unit
// (the prefix-sum decoder).
package adjacent_difference_1x8x32bit_pkg;

    localparam int LANES = 8;
    localparam int W     = 32;
    localparam int LAT   = 3;
    localparam int VW    = LANES * W;

    // Lowest bit of lane k inside a packed vector.
    function automatic int lane_lo(input int k);
        return k * W;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/adjacent_difference_1x8x32bit_sub.sv
// Registered lane subtractor: out <= inA - inB.
// With ADJDIFF_SIGNED_SAT_EN defined, the difference is signed and saturating.
module sub_module
    import adjacent_difference_1x8x32bit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic [W-1:0] out
);

    logic [W-1:0] diff;
    logic [W-1:0] res;

`ifdef ADJDIFF_SIGNED_SAT_EN
    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};
    logic ovf;

    // Overflow only when the operand signs differ and the result sign disagrees with inA.
    always_comb begin
        diff = inA - inB;
        ovf  = (inA[W-1] != inB[W-1]) && (diff[W-1] != inA[W-1]);
        res  = diff;
        if (ovf) begin
            res = inA[W-1] ? NEG_MIN : POS_MAX;
        end
    end
`else
    always_comb begin
        diff = inA - inB;
        res  = diff;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else begin
            out <= res;
        end
    end

endmodule

// File: rtl/adjacent_difference_1x8x32bit.sv
// Adjacent-difference SIMD unit: out lane k = in lane k - in lane k-1, lane 0 uses the
// previous vector's lane 7 as its predecessor. Optional macro: ADJDIFF_SIGNED_SAT_EN.
module adjacent_difference_1x8x32bit
    import adjacent_difference_1x8x32bit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_v,
    input  logic [2:0]    vrd,
    input  logic [255:0]  in8,
    output logic          out_v,
    output logic [255:0]  out8,
    output logic [2:0]    out_vrd,
    output logic [31:0]   out_carry,
    output logic [15:0]   out_count
);

    // Handshake: in_v accepts one vector per cycle, unconditionally (no ready, no
    // backpressure); out_v pulses for exactly one cycle LAT cycles later with out8/out_vrd.

    logic [LAT-1:0]      v_sr;
    logic [LAT-1:0][2:0] vrd_sr;
    logic [VW-1:0]       x1;
    logic [W-1:0]        prev1;
    logic [W-1:0]        carry;
    logic [15:0]         count;
    logic [VW-1:0]       d;
    logic [VW-1:0]       out8_r;

    // Stage 1: capture the vector and its lane-0 predecessor; carry advances here so
    // back-to-back vectors see the previous vector's lane 7 without a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_sr   <= '0;
            vrd_sr <= '0;
            x1     <= '0;
            prev1  <= '0;
            carry  <= '0;
            count  <= '0;
        end else begin
            v_sr   <= {v_sr[LAT-2:0], in_v};
            vrd_sr <= {vrd_sr[LAT-2:0], vrd};
            if (in_v) begin
                x1    <= in8;
                prev1 <= (vrd == 3'd0) ? '0 : carry;
                carry <= in8[lane_lo(LANES-1) +: W];
                count <= (vrd == 3'd0) ? 16'd1 : sat_inc16(count);
            end
        end
    end

    // Stage 2: one registered subtractor per lane.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [W-1:0] pred;
        if (k == 0) begin : g_first
            assign pred = prev1;
        end else begin : g_rest
            assign pred = x1[lane_lo(k-1) +: W];
        end
        sub_module u_sub (
            .clk   (clk),
            .reset (reset),
            .inA   (x1[lane_lo(k) +: W]),
            .inB   (pred),
            .out   (d[lane_lo(k) +: W])
        );
    end

    // Stage 3: out8 only loads when a real result is in stage 2, so it holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out8_r <= '0;
        end else if (v_sr[LAT-2]) begin
            out8_r <= d;
        end
    end

    assign out_v     = v_sr[LAT-1];
    assign out_vrd   = vrd_sr[LAT-1];
    assign out8      = out8_r;
    assign out_carry = carry;
    assign out_count = count;

endmodule

// File: tb/tb_adjacent_difference_1x8x32bit.sv
// Scoreboard bench for adjacent_difference_1x8x32bit: directed vectors, prefix-sum
// round trip, mid-flight reset and count saturation.
module tb_adjacent_difference_1x8x32bit;

  logic         clk;
  logic         reset;
  logic         in_v;
  logic [2:0]   vrd;
  logic [255:0] in8;
  logic         out_v;
  logic [255:0] out8;
  logic [2:0]   out_vrd;
  logic [31:0]  out_carry;
  logic [15:0]  out_count;

  adjacent_difference_1x8x32bit dut (
    .clk       (clk),
    .reset     (reset),
    .in_v      (in_v),
    .vrd       (vrd),
    .in8       (in8),
    .out_v     (out_v),
    .out8      (out8),
    .out_vrd   (out_vrd),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [258:0] exp_q[$];
  int tb_checks   = 0;
  int tb_errors   = 0;
  int sb_checks   = 0;
  int sb_errors   = 0;
  int out_v_total = 0;

  function automatic logic [255:0] pack8(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3,
                                         input logic [31:0] a4, input logic [31:0] a5,
                                         input logic [31:0] a6, input logic [31:0] a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tb_checks++;
    if (act !== req) begin
      tb_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] v, input logic [255:0] data,
                      input logic [255:0] expv, input bit push);
    in_v = 1'b1;
    vrd  = v;
    in8  = data;
    if (push) exp_q.push_back({v, expv});
    @(posedge clk);
    #1;
    in_v = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    tb_checks++;
    if (exp_q.size() != 0) begin
      tb_errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [258:0] e;
    if (out_v === 1'b1) begin
      out_v_total++;
      sb_checks++;
      if (exp_q.size() == 0) begin
        sb_errors++;
        $display("FAIL unexpected_out_v: got out_v=1 vrd=%0d, expected no result", out_vrd);
      end else begin
        e = exp_q.pop_front();
        if ({out_vrd, out8} !== e) begin
          sb_errors++;
          $display("FAIL result: got vrd=%0d out8=%h expected vrd=%0d out8=%h",
                   out_vrd, out8, e[258:256], e[255:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0]  acc;
    logic [255:0] x;
    logic [255:0] ps;
    logic [31:0]  r;
    logic [2:0]   v;
    int           base;

    reset = 1'b0;
    in_v  = 1'b0;
    vrd   = 3'd0;
    in8   = '0;
    idle(2);
    check("reset_out_v", {255'b0, out_v}, 256'd0);
    check("reset_out8", out8, 256'd0);
    check("reset_out_vrd", {253'b0, out_vrd}, 256'd0);
    check("reset_carry", {224'b0, out_carry}, 256'd0);
    check("reset_count", {240'b0, out_count}, 256'd0);
    reset = 1'b1;
    idle(1);
    check("post_release_out_v", {255'b0, out_v}, 256'd0);
    check("post_release_count", {240'b0, out_count}, 256'd0);

    // Basic decode of a prefix-summed ramp and its continuation.
    send(3'd0, pack8(1, 3, 6, 10, 15, 21, 28, 36), pack8(1, 2, 3, 4, 5, 6, 7, 8), 1'b1);
    check("v1_carry", {224'b0, out_carry}, 256'd36);
    check("v1_count", {240'b0, out_count}, 256'd1);
    send(3'd2, pack8(45, 55, 66, 78, 91, 105, 120, 136),
         pack8(9, 10, 11, 12, 13, 14, 15, 16), 1'b1);
    check("v2_carry", {224'b0, out_carry}, 256'd136);
    check("v2_count", {240'b0, out_count}, 256'd2);
    idle(1);

    // Modulo-2^32 wrap; identical under signed saturation since nothing overflows.
    send(3'd0, pack8(0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0),
         pack8(0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0), 1'b1);
    check("wrap_count", {240'b0, out_count}, 256'd1);
    check("wrap_carry", {224'b0, out_carry}, 256'd0);
`ifdef ADJDIFF_SIGNED_SAT_EN
    // 0x7FFFFFFF - 0x80000000 overflows positive and clamps; 0 - 0x7FFFFFFF does not overflow.
    send(3'd0, pack8(32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0),
         pack8(32'h80000000, 32'h7FFFFFFF, 32'h80000001, 0, 0, 0, 0, 0), 1'b1);
`endif
    drain();

`ifndef ADJDIFF_SIGNED_SAT_EN
    // Round trip: feed running prefix sums, expect the original elements back.
    base = out_v_total;
    acc  = '0;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 8; k++) begin
        r = $urandom;
        x[k*32 +: 32] = r;
        acc = acc + r;
        ps[k*32 +: 32] = acc;
      end
      v = (i == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      send(v, ps, x, 1'b1);
      idle($urandom_range(0, 2));
    end
    drain();
    check("roundtrip_out_v_count", 256'(out_v_total - base), 256'd64);
`endif

    // Reset pulse with two vectors in flight: neither may appear.
    base = out_v_total;
    send(3'd0, pack8(5, 6, 7, 8, 9, 10, 11, 12), '0, 1'b0);
    send(3'd1, pack8(20, 21, 22, 23, 24, 25, 26, 27), '0, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    idle(1);
    reset = 1'b1;
    check("pulse_carry", {224'b0, out_carry}, 256'd0);
    check("pulse_count", {240'b0, out_count}, 256'd0);
    idle(6);
    check("pulse_no_out_v", 256'(out_v_total - base), 256'd0);

    // Count saturation: one stream start then 65536 continuation vectors.
    send(3'd0, '0, '0, 1'b1);
    for (int i = 0; i < 65536; i++) begin
      send(3'd3, '0, '0, 1'b1);
      if (i == 65532) check("count_fffe", {240'b0, out_count}, 256'hFFFE);
      if (i == 65533) check("count_ffff", {240'b0, out_count}, 256'hFFFF);
    end
    check("count_stuck", {240'b0, out_count}, 256'hFFFF);
    check("count_vrd_last", {253'b0, vrd}, 256'd3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             tb_checks + sb_checks, tb_errors + sb_errors);
    $finish;
  end

endmodule
